// File: rtl/id_control_unit_pkg.sv
// id_control_unit_pkg: shared encodings for the ID-stage control unit.
// Contents: instruction-class codes, ALU opcodes, addressing modes,
//           condition codes and the packed control bundle.
package id_control_unit_pkg;

  // instruction[27:25] classes
  localparam logic [2:0] CLS_DP_REG  = 3'b000;
  localparam logic [2:0] CLS_DP_IMM  = 3'b001;
  localparam logic [2:0] CLS_LS_IMM  = 3'b010;
  localparam logic [2:0] CLS_LS_REG  = 3'b011;
  localparam logic [2:0] CLS_BRANCH  = 3'b101;

  // ALU opcodes (instruction[24:21] for data-processing)
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Shifter addressing modes
  localparam logic [1:0] AM_DP_IMM = 2'b00;
  localparam logic [1:0] AM_DP_REG = 2'b01;
  localparam logic [1:0] AM_LS_IMM = 2'b10;
  localparam logic [1:0] AM_LS_REG = 2'b11;

  // Condition codes (instruction[31:28])
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Decoded control bundle; all-zero is the bubble/NOP value.
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] am;
    logic       s_enable;
    logic       load_instr;
    logic       rf_enable;
    logic       size_enable;
    logic       rw_enable;
    logic       mem_enable;
    logic       bl_instr;
    logic       b_instr;
  } ctrl_t;

endpackage

// File: rtl/id_control_unit_cond_eval.sv
// cond_eval: ARM condition-code evaluator, purely combinational.
// Ports: cond[3:0] condition field, flags[3:0] {N,Z,C,V},
//        cond_true = 1 when the condition holds.
module cond_eval
  import id_control_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;
  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_EQ: cond_true = z;
      CC_NE: cond_true = ~z;
      CC_CS: cond_true = c;
      CC_CC: cond_true = ~c;
      CC_MI: cond_true = n;
      CC_PL: cond_true = ~n;
      CC_VS: cond_true = v;
      CC_VC: cond_true = ~v;
      CC_HI: cond_true = c & ~z;
      CC_LS: cond_true = ~c | z;
      CC_GE: cond_true = (n == v);
      CC_LT: cond_true = (n != v);
      CC_GT: cond_true = ~z & (n == v);
      CC_LE: cond_true = z | (n != v);
      CC_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;  // NV: never
    endcase
  end

endmodule

// File: rtl/id_control_unit.sv
// id_control_unit: ID-stage decoder producing datapath controls, bubble mux
// and B/BL taken signals. Zero-cycle combinational outputs; taken_q is one
// register (sync active-high reset R). S=1 forces all controls to zero.
// Ports: clk, R, instruction[31:0], flags[3:0] {N,Z,C,V}, S (bubble);
//        ID_* controls, Branch, BranchL, taken_q, keyword[47:0].
// Optional macro CU_KEYWORD_EN: drives keyword with an ASCII mnemonic,
// otherwise keyword is tied to zero.
module id_control_unit
  import id_control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] instruction,
  input  logic [3:0]  flags,
  input  logic        S,
  output logic [3:0]  ID_opcode,
  output logic [1:0]  ID_AM,
  output logic        ID_S_enable,
  output logic        ID_load_instr,
  output logic        ID_RF_enable,
  output logic        ID_Size_enable,
  output logic        ID_RW_enable,
  output logic        ID_Enable_signal,
  output logic        ID_BL_instr,
  output logic        ID_B_instr,
  output logic        Branch,
  output logic        BranchL,
  output logic        taken_q,
  output logic [47:0] keyword
);

  ctrl_t      dec;
  ctrl_t      ctl;
  logic [2:0] cls;
  logic       is_zero;
  logic       cond_true;

  assign cls     = instruction[27:25];
  assign is_zero = (instruction == 32'd0);

  // Register fields and offsets are consumed by other ID-stage logic.
  logic unused_fields;
  assign unused_fields = ^instruction[19:0];

  always_comb begin
    dec = '0;
    if (!is_zero) begin
      case (cls)
        CLS_DP_REG, CLS_DP_IMM: begin
          dec.opcode    = instruction[24:21];
          dec.s_enable  = instruction[20];
          dec.am        = (cls == CLS_DP_IMM) ? AM_DP_IMM : AM_DP_REG;
          // TST/TEQ/CMP/CMN (10xx) only set flags, no register write
          dec.rf_enable = (instruction[24:23] != 2'b10);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          dec.opcode      = instruction[23] ? OP_ADD : OP_SUB;
          dec.am          = (cls == CLS_LS_IMM) ? AM_LS_IMM : AM_LS_REG;
          dec.mem_enable  = 1'b1;
          dec.load_instr  = instruction[20];
          dec.rf_enable   = instruction[20];
          dec.rw_enable   = ~instruction[20];
          dec.size_enable = ~instruction[22];
        end
        CLS_BRANCH: begin
          dec.b_instr  = ~instruction[24];
          dec.bl_instr = instruction[24];
        end
        default: dec = '0;
      endcase
    end
  end

  // Bubble mux
  assign ctl = S ? ctrl_t'('0) : dec;

  assign ID_opcode        = ctl.opcode;
  assign ID_AM            = ctl.am;
  assign ID_S_enable      = ctl.s_enable;
  assign ID_load_instr    = ctl.load_instr;
  assign ID_RF_enable     = ctl.rf_enable;
  assign ID_Size_enable   = ctl.size_enable;
  assign ID_RW_enable     = ctl.rw_enable;
  assign ID_Enable_signal = ctl.mem_enable;
  assign ID_BL_instr      = ctl.bl_instr;
  assign ID_B_instr       = ctl.b_instr;

  cond_eval u_cond_eval (
    .cond      (instruction[31:28]),
    .flags     (flags),
    .cond_true (cond_true)
  );

  // Post-mux controls are used, so a stalled branch never fires.
  assign Branch  = cond_true & (ctl.b_instr | ctl.bl_instr);
  assign BranchL = cond_true & ctl.bl_instr;

  always_ff @(posedge clk) begin
    if (R) taken_q <= 1'b0;
    else   taken_q <= Branch | BranchL;
  end

`ifdef CU_KEYWORD_EN
  always_comb begin
    keyword = "NOP   ";
    if (!S && !is_zero) begin
      case (cls)
        CLS_DP_REG, CLS_DP_IMM: begin
          case (instruction[24:21])
            OP_AND: keyword = "AND   ";
            OP_EOR: keyword = "EOR   ";
            OP_SUB: keyword = "SUB   ";
            OP_RSB: keyword = "RSB   ";
            OP_ADD: keyword = "ADD   ";
            OP_ADC: keyword = "ADC   ";
            OP_SBC: keyword = "SBC   ";
            OP_RSC: keyword = "RSC   ";
            OP_TST: keyword = "TST   ";
            OP_TEQ: keyword = "TEQ   ";
            OP_CMP: keyword = "CMP   ";
            OP_CMN: keyword = "CMN   ";
            OP_ORR: keyword = "ORR   ";
            OP_MOV: keyword = "MOV   ";
            OP_BIC: keyword = "BIC   ";
            default: keyword = "MVN   ";
          endcase
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          case ({instruction[20], instruction[22]})
            2'b10:   keyword = "LDR   ";
            2'b11:   keyword = "LDRB  ";
            2'b00:   keyword = "STR   ";
            default: keyword = "STRB  ";
          endcase
        end
        CLS_BRANCH: keyword = instruction[24] ? "BL    " : "B     ";
        default:    keyword = "NOP   ";
      endcase
    end
  end
`else
  assign keyword = 48'd0;
`endif

endmodule

// File: tb/tb_id_control_unit.sv
// tb_id_control_unit: directed self-checking bench for id_control_unit.
// Control vector order: {opcode, AM, S_en, load, RF, Size, RW, E, BL, B}.
module tb_id_control_unit;

  logic        clk = 1'b0;
  logic        R;
  logic [31:0] instruction;
  logic [3:0]  flags;
  logic        S;
  logic [3:0]  ID_opcode;
  logic [1:0]  ID_AM;
  logic        ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
  logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
  logic        Branch, BranchL, taken_q;
  logic [47:0] keyword;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_control_unit dut (
    .clk(clk), .R(R), .instruction(instruction), .flags(flags), .S(S),
    .ID_opcode(ID_opcode), .ID_AM(ID_AM), .ID_S_enable(ID_S_enable),
    .ID_load_instr(ID_load_instr), .ID_RF_enable(ID_RF_enable),
    .ID_Size_enable(ID_Size_enable), .ID_RW_enable(ID_RW_enable),
    .ID_Enable_signal(ID_Enable_signal), .ID_BL_instr(ID_BL_instr),
    .ID_B_instr(ID_B_instr), .Branch(Branch), .BranchL(BranchL),
    .taken_q(taken_q), .keyword(keyword)
  );

  logic [13:0] ctl_obs;
  assign ctl_obs = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                    ID_Size_enable, ID_RW_enable, ID_Enable_signal,
                    ID_BL_instr, ID_B_instr};

  task automatic apply(input logic [31:0] ins, input logic [3:0] fl, input logic s);
    @(negedge clk);
    instruction = ins;
    flags       = fl;
    S           = s;
    #1;
  endtask

  task automatic test_reset;
    R = 1'b1;
    apply(32'hEA000000, 4'b0000, 1'b0);  // BAL taken while reset is held
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b0) begin
      n_fail++; $display("FAIL reset_taken_q: got %b want 0", taken_q);
    end
    apply(32'h0000_0000, 4'b1111, 1'b0);
    n_checks++;
    if ({ctl_obs, Branch, BranchL} !== 16'd0) begin
      n_fail++; $display("FAIL zero_instr_nop: got %h want 0", {ctl_obs, Branch, BranchL});
    end
    R = 1'b0;
  endtask

  task automatic test_data_proc;
    apply(32'hE2821005, 4'b0000, 1'b0);  // ADD R1,R2,#5
    n_checks++;
    if (ctl_obs !== 14'b0100_00_0_0_1_0_0_0_0_0) begin
      n_fail++; $display("FAIL add_imm: got %b want %b", ctl_obs, 14'b0100_00_0_0_1_0_0_0_0_0);
    end
    n_checks++;
`ifdef CU_KEYWORD_EN
    if (keyword !== "ADD   ") begin
      n_fail++; $display("FAIL add_keyword: got %h", keyword);
    end
`else
    if (keyword !== 48'd0) begin
      n_fail++; $display("FAIL add_keyword: got %h want 0", keyword);
    end
`endif
    apply(32'hE1510002, 4'b0000, 1'b0);  // CMP R1,R2
    n_checks++;
    if (ctl_obs !== 14'b1010_01_1_0_0_0_0_0_0_0) begin
      n_fail++; $display("FAIL cmp_reg: got %b want %b", ctl_obs, 14'b1010_01_1_0_0_0_0_0_0_0);
    end
    apply(32'hE8000000, 4'b0000, 1'b0);  // class 100: treated as NOP
    n_checks++;
    if (ctl_obs !== 14'd0) begin
      n_fail++; $display("FAIL class100_nop: got %b want 0", ctl_obs);
    end
  endtask

  task automatic test_load_store;
    apply(32'hE5921004, 4'b0000, 1'b0);  // LDR R1,[R2,#4]
    n_checks++;
    if (ctl_obs !== 14'b0100_10_0_1_1_1_0_1_0_0) begin
      n_fail++; $display("FAIL ldr_imm: got %b want %b", ctl_obs, 14'b0100_10_0_1_1_1_0_1_0_0);
    end
    apply(32'hE5421001, 4'b0000, 1'b0);  // STRB R1,[R2,#-1]
    n_checks++;
    if (ctl_obs !== 14'b0010_10_0_0_0_0_1_1_0_0) begin
      n_fail++; $display("FAIL strb_imm: got %b want %b", ctl_obs, 14'b0010_10_0_0_0_0_1_1_0_0);
    end
    apply(32'hE7921003, 4'b0000, 1'b0);  // LDR R1,[R2,R3]
    n_checks++;
    if (ctl_obs !== 14'b0100_11_0_1_1_1_0_1_0_0) begin
      n_fail++; $display("FAIL ldr_reg: got %b want %b", ctl_obs, 14'b0100_11_0_1_1_1_0_1_0_0);
    end
  endtask

  task automatic test_branch;
    apply(32'h0A000002, 4'b0100, 1'b0);  // BEQ, Z=1
    n_checks++;
    if ({ctl_obs, Branch, BranchL} !== {14'b0000_00_0_0_0_0_0_0_0_1, 2'b10}) begin
      n_fail++; $display("FAIL beq_taken: got %b want %b", {ctl_obs, Branch, BranchL},
                         {14'b0000_00_0_0_0_0_0_0_0_1, 2'b10});
    end
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken_q: got %b want 1", taken_q);
    end
    apply(32'h0A000002, 4'b0000, 1'b0);  // BEQ, Z=0
    n_checks++;
    if (Branch !== 1'b0) begin
      n_fail++; $display("FAIL beq_not_taken: got %b want 0", Branch);
    end
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b0) begin
      n_fail++; $display("FAIL beq_not_taken_q: got %b want 0", taken_q);
    end
    apply(32'hEB000001, 4'b0000, 1'b0);  // BL
    n_checks++;
    if ({ID_BL_instr, ID_B_instr, Branch, BranchL} !== 4'b1011) begin
      n_fail++; $display("FAIL bl_taken: got %b want 1011", {ID_BL_instr, ID_B_instr, Branch, BranchL});
    end
    // Condition table spot checks: {cond instr, flags, expected Branch}
    apply(32'hCA000000, 4'b1001, 1'b0);  // GT, N=V=1, Z=0
    n_checks++;
    if (Branch !== 1'b1) begin n_fail++; $display("FAIL gt_true: got %b want 1", Branch); end
    apply(32'hCA000000, 4'b1000, 1'b0);  // GT, N!=V
    n_checks++;
    if (Branch !== 1'b0) begin n_fail++; $display("FAIL gt_false: got %b want 0", Branch); end
    apply(32'h9A000000, 4'b0010, 1'b0);  // LS, C=1 Z=0
    n_checks++;
    if (Branch !== 1'b0) begin n_fail++; $display("FAIL ls_false: got %b want 0", Branch); end
    apply(32'h9A000000, 4'b0000, 1'b0);  // LS, C=0
    n_checks++;
    if (Branch !== 1'b1) begin n_fail++; $display("FAIL ls_true: got %b want 1", Branch); end
    apply(32'hFA000000, 4'b1111, 1'b0);  // NV never
    n_checks++;
    if (Branch !== 1'b0) begin n_fail++; $display("FAIL nv_never: got %b want 0", Branch); end
  endtask

  task automatic test_bubble;
    apply(32'hEB000001, 4'b0000, 1'b1);  // BL stalled
    n_checks++;
    if ({ctl_obs, Branch, BranchL} !== 16'd0) begin
      n_fail++; $display("FAIL bubble_bl: got %b want 0", {ctl_obs, Branch, BranchL});
    end
`ifdef CU_KEYWORD_EN
    n_checks++;
    if (keyword !== "NOP   ") begin
      n_fail++; $display("FAIL bubble_keyword: got %h", keyword);
    end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b0) begin
      n_fail++; $display("FAIL bubble_taken_q: got %b want 0", taken_q);
    end
  endtask

  task automatic test_back_to_back;
    apply(32'hEB000001, 4'b0000, 1'b0);  // BL taken
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b1) begin
      n_fail++; $display("FAIL b2b_taken_q: got %b want 1", taken_q);
    end
    R = 1'b1;                            // reset wins over taken branch
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b0) begin
      n_fail++; $display("FAIL reset_wins: got %b want 0", taken_q);
    end
    R = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (taken_q !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_taken_q: got %b want 1", taken_q);
    end
  endtask

  initial begin
    R = 1'b1; instruction = '0; flags = '0; S = 1'b0;
    test_reset;
    test_data_proc;
    test_load_store;
    test_branch;
    test_bubble;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
